trail_map: RTL and testbench
============================

Name: trail_map

Overview:
- Parametrised successor to the two-bike trail store: keeps the per-cell trail map of the arena for N players and detects collisions.
- Each frame step it processes every player in turn with a read-check-write pass over a single engine-side RAM port.
- A separate 1-cycle read port serves the renderer.
- Clearing is a sequenced sweep, not a bulk assignment, so the RAM maps onto on-chip block memory.

Parameters:
- GRID_W, 112, arena width in cells.
- GRID_H, 112, arena height in cells.
- N_PLAYERS, 2, number of bikes (1..8).
- XW, $clog2(GRID_W), x coordinate width (derived).
- YW, $clog2(GRID_H), y coordinate width (derived).
- PW, max(1,$clog2(N_PLAYERS)), owner-id width (derived).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; starts a clear sweep
- clear_req  in  1  pulse: wipe map and collision flags
- step  in  1  pulse: new positions valid, start a pass
- pos_x  in  N_PLAYERS*XW  packed x per player (player 0 in the LSBs)
- pos_y  in  N_PLAYERS*YW  packed y per player
- dir  in  N_PLAYERS*2  packed direction: 0 up, 1 down, 2 left, 3 right
- busy  out  1  high while clearing or during a pass
- done  out  1  one-cycle pulse when a pass completes
- step_dropped  out  1  one-cycle pulse when a step arrives while busy
- collision  out  N_PLAYERS  sticky per-player collision flags
- rd_x  in  XW  render read x
- rd_y  in  YW  render read y
- rd_data  out  PW+2  cell at (rd_x,rd_y), one cycle later

Behaviour:
- Cell encoding is {owner, shape}. Shape codes: 0 EMPTY, 1 HORIZ, 2 VERT, 3 CORNER. A cell is occupied iff its shape is nonzero.
- Address = y*GRID_W + x. Depth = GRID_W*GRID_H.

Reset:
- busy=1, done=0, step_dropped=0, collision=0.
- All per-player history valid bits are cleared.
- The FSM enters CLEAR.

FSM states: CLEAR, IDLE, LATCH, RD, CHK, DONE.
- CLEAR: writes 0 to address ptr, ptr++ each cycle. Takes GRID_W*GRID_H cycles, then goes to IDLE with busy=0.
- IDLE: on step, latches pos/dir for all players (stable snapshot), sets busy, goes to LATCH.
- LATCH: computes pairwise same-cell matches among moved players. Every player in a matching pair gets its collision flag set. Sets player index i=0, goes to RD.
- RD, for player i:
  - If the position equals stored old_pos and the history is valid, the player is skipped (no read, no write).
  - If out of bounds (x>=GRID_W or y>=GRID_H), collision[i] is set with no RAM access.
  - Otherwise the engine issues a RAM read and goes to CHK.
- CHK:
  - Read data occupied -> collision[i] set.
  - Writes {i, shape}. Shape is CORNER if dir!=old_dir and the history is valid; else VERT for dir 0/1; else HORIZ for dir 2/3.
  - Updates old_pos/old_dir and sets the valid bit.
  - i++. When the last player is done, goes to DONE, else RD.
- DONE: done=1 for one cycle, busy=0, returns to IDLE.

Timing and flags:
- Worst-case pass latency: 2*N_PLAYERS+2 cycles from step to done.
- The first step after a clear treats every player as moved.
- Collision flags are sticky until clear_req or Reset. A collided player keeps being processed; the game FSM decides the outcome.

Boundary conditions:
- step while busy: ignored; step_dropped pulses for one cycle.
- clear_req in any state: aborts the current pass with no partial write and enters CLEAR. Collisions and history valid bits are zeroed.
- clear_req and step in the same cycle: clear wins and step_dropped pulses.
- Reset mid-pass or mid-clear: restarts CLEAR from address 0.

Render port:
- The render port reads independently of the engine port.
- While in CLEAR, rd_data is forced to 0.
- A same-address engine write and render read in the same cycle return the old data.

Decomposition:
- trail_pkg holds:
  - shape_e enum (EMPTY, HORIZ, VERT, CORNER)
  - dir_e enum (UP, DOWN, LEFT, RIGHT)
  - state_e for the FSM
  - function make_cell(owner, shape)
- Sub-module trail_ram, parametrised by depth and width:
  - one synchronous read/write engine port
  - one synchronous read-only render port
  - no reset on the array

Test Plan:
- Reset held 1 cycle, GRID 8x8, N=2 -> busy=1 for exactly 64 cycles, then 0; rd_data at (3,3) reads 0.
- P0 moves (1,1) right to (2,1), P1 moves (5,5) to (5,4) with dir up -> done 6 cycles after step; cell (2,1)=HORIZ owner 0; cell (5,4)=VERT owner 1; collision=00.
- P0 changes dir right->down entering (2,2) -> cell (2,2)=CORNER; a later step onto (2,1) -> collision[0]=1, sticky across two further steps.
- P0 and P1 both step to empty (4,4) -> collision=11; cell (4,4) holds owner 0.
- P1 at x=8 on an 8-wide grid -> collision[1]=1 with no RAM write; P0 processed normally.
- step asserted 1 cycle after a previous step -> step_dropped pulse, one done only.
- clear_req during CHK -> no write of that cell, collision=0, 64-cycle sweep restarts.

Source files
------------

// File: rtl/trail_pkg.sv
// trail_pkg: shared types for the trail map engine.
//   shape_e  - shape code stored in the low two bits of every cell
//   dir_e    - bike heading as presented on the dir port
//   state_e  - engine FSM states
//   make_cell(owner, shape) - packs a cell word {owner, shape}; callers
//                             truncate to their real owner width
package trail_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HORIZ  = 2'd1,
        VERT   = 2'd2,
        CORNER = 2'd3
    } shape_e;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LATCH,
        ST_RD,
        ST_CHK,
        ST_DONE
    } state_e;

    // Up to 8 players, so owner ids never need more than 3 bits.
    localparam int OWNER_MAX_W = 3;

    function automatic logic [OWNER_MAX_W+1:0] make_cell(input logic [OWNER_MAX_W-1:0] owner,
                                                         input shape_e                 shape);
        return {owner, shape};
    endfunction

endpackage

// File: rtl/trail_ram.sv
// trail_ram: simple dual-port RAM holding the arena cells.
//   clk        in   clock
//   eng_en     in   engine port access enable
//   eng_we     in   engine port write enable (read-first on the same access)
//   eng_addr   in   engine port address
//   eng_wdata  in   engine port write data
//   eng_rdata  out  engine port read data, one cycle after the access
//   rd_addr    in   render port address
//   rd_data    out  render port read data, one cycle later
// The array has no reset so it can map onto block memory. A render read
// of the address the engine is writing in the same cycle returns old data.
module trail_ram #(
    parameter  int DEPTH = 64,
    parameter  int WIDTH = 3,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             eng_en,
    input  logic             eng_we,
    input  logic [AW-1:0]    eng_addr,
    input  logic [WIDTH-1:0] eng_wdata,
    output logic [WIDTH-1:0] eng_rdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (eng_en) begin
            if (eng_we) begin
                mem[eng_addr] <= eng_wdata;
            end
            eng_rdata <= mem[eng_addr];
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trail_map.sv
// trail_map: per-cell trail store for N bikes with collision detection.
//   Clk           in   system clock
//   Reset         in   synchronous active-high reset; starts a clear sweep
//   clear_req     in   pulse: wipe map, collision flags and move history
//   step          in   pulse: positions valid, run one read-check-write pass
//   pos_x/pos_y   in   packed coordinates per player (player 0 in the LSBs)
//   dir           in   packed 2-bit headings (0 up, 1 down, 2 left, 3 right)
//   busy          out  high while clearing or during a pass
//   done          out  one-cycle pulse at the end of a pass
//   step_dropped  out  one-cycle pulse when a step is refused
//   collision     out  sticky per-player collision flags
//   rd_x/rd_y     in   render read coordinate
//   rd_data       out  cell {owner, shape} at (rd_x, rd_y), one cycle later
//
// XW/YW default to the minimum coordinate width; they may be widened so
// that off-arena coordinates can be presented and flagged.
module trail_map
    import trail_pkg::*;
#(
    parameter int GRID_W    = 112,
    parameter int GRID_H    = 112,
    parameter int N_PLAYERS = 2,
    parameter int XW        = $clog2(GRID_W),
    parameter int YW        = $clog2(GRID_H),
    parameter int PW        = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   clear_req,
    input  logic                   step,
    input  logic [N_PLAYERS*XW-1:0] pos_x,
    input  logic [N_PLAYERS*YW-1:0] pos_y,
    input  logic [N_PLAYERS*2-1:0]  dir,
    output logic                   busy,
    output logic                   done,
    output logic                   step_dropped,
    output logic [N_PLAYERS-1:0]   collision,
    input  logic [XW-1:0]          rd_x,
    input  logic [YW-1:0]          rd_y,
    output logic [PW+1:0]          rd_data
);

    localparam int DEPTH = GRID_W * GRID_H;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PW + 2;

    state_e               state;
    logic [AW-1:0]        ptr;
    logic [PW-1:0]        idx;

    logic [XW-1:0]        snap_x   [N_PLAYERS];
    logic [YW-1:0]        snap_y   [N_PLAYERS];
    logic [1:0]           snap_dir [N_PLAYERS];
    logic [XW-1:0]        old_x    [N_PLAYERS];
    logic [YW-1:0]        old_y    [N_PLAYERS];
    logic [1:0]           old_dir  [N_PLAYERS];
    logic [N_PLAYERS-1:0] hist_valid;

    logic [N_PLAYERS-1:0] moved;
    logic [N_PLAYERS-1:0] pair_hit;
    logic [XW-1:0]        cur_x;
    logic [YW-1:0]        cur_y;
    dir_e                 cur_dir;
    logic                 cur_moved;
    logic                 cur_oob;
    logic                 last;
    logic                 advance;
    logic                 abort;
    logic                 occupied;
    shape_e               cur_shape;
    logic [AW-1:0]        cur_addr;

    logic                 eng_en;
    logic                 eng_we;
    logic [AW-1:0]        eng_addr;
    logic [CW-1:0]        eng_wdata;
    logic [CW-1:0]        eng_rdata;
    logic [AW-1:0]        rd_addr;
    logic [CW-1:0]        ram_rd_data;
    logic                 rd_in_clear;
    logic                 unused_rdata;

    // A player whose snapshot equals its last written cell is standing still.
    always_comb begin
        moved = '0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            moved[p] = !(hist_valid[p] && snap_x[p] == old_x[p] && snap_y[p] == old_y[p]);
        end
    end

    always_comb begin
        pair_hit = '0;
        for (int a = 0; a < N_PLAYERS; a++) begin
            for (int b = a + 1; b < N_PLAYERS; b++) begin
                if (moved[a] && moved[b] && snap_x[a] == snap_x[b] && snap_y[a] == snap_y[b]) begin
                    pair_hit[a] = 1'b1;
                    pair_hit[b] = 1'b1;
                end
            end
        end
    end

    assign cur_x     = snap_x[idx];
    assign cur_y     = snap_y[idx];
    assign cur_dir   = dir_e'(snap_dir[idx]);
    assign cur_moved = moved[idx];
    assign cur_oob   = (32'(cur_x) >= 32'(GRID_W)) || (32'(cur_y) >= 32'(GRID_H));
    assign cur_addr  = AW'(32'(cur_y) * 32'(GRID_W) + 32'(cur_x));
    assign last      = (idx == PW'(N_PLAYERS - 1));
    assign occupied  = |eng_rdata[1:0];
    assign abort     = Reset || clear_req;

    always_comb begin
        cur_shape = VERT;
        if (hist_valid[idx] && snap_dir[idx] != old_dir[idx]) begin
            cur_shape = CORNER;
        end else if (cur_dir == LEFT || cur_dir == RIGHT) begin
            cur_shape = HORIZ;
        end
    end

    // Skipped and off-arena players finish in RD; everyone else in CHK.
    assign advance = (state == ST_RD && (!cur_moved || cur_oob)) || (state == ST_CHK);

    // Writes are gated by abort so a clear landing on CHK leaves the cell untouched.
    assign eng_en    = (state == ST_CLEAR) || (state == ST_CHK) ||
                       (state == ST_RD && cur_moved && !cur_oob);
    assign eng_we    = !abort && ((state == ST_CLEAR) || (state == ST_CHK && !occupied));
    assign eng_addr  = (state == ST_CLEAR) ? ptr : cur_addr;
    assign eng_wdata = (state == ST_CLEAR) ? '0 : CW'(make_cell(3'(idx), cur_shape));

    assign rd_addr = AW'(32'(rd_y) * 32'(GRID_W) + 32'(rd_x));

    trail_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_ram (
        .clk       (Clk),
        .eng_en    (eng_en),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_rdata (eng_rdata),
        .rd_addr   (rd_addr),
        .rd_data   (ram_rd_data)
    );

    // A render read issued during the sweep may return a not-yet-cleared
    // cell, so the mask follows the read by one cycle as well.
    always_ff @(posedge Clk) begin
        rd_in_clear <= Reset || (state == ST_CLEAR);
    end

    assign rd_data      = (state == ST_CLEAR || rd_in_clear) ? '0 : ram_rd_data;
    assign unused_rdata = ^eng_rdata;

    always_ff @(posedge Clk) begin
        done         <= 1'b0;
        step_dropped <= 1'b0;
        if (abort) begin
            state        <= ST_CLEAR;
            ptr          <= '0;
            idx          <= '0;
            busy         <= 1'b1;
            collision    <= '0;
            hist_valid   <= '0;
            step_dropped <= !Reset && step;
        end else begin
            if (step && busy) begin
                step_dropped <= 1'b1;
            end
            unique case (state)
                ST_CLEAR: begin
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    if (step) begin
                        for (int p = 0; p < N_PLAYERS; p++) begin
                            snap_x[p]   <= pos_x[p*XW +: XW];
                            snap_y[p]   <= pos_y[p*YW +: YW];
                            snap_dir[p] <= dir[p*2 +: 2];
                        end
                        busy  <= 1'b1;
                        state <= ST_LATCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    collision <= collision | pair_hit;
                    idx       <= '0;
                    state     <= ST_RD;
                end
                ST_RD: begin
                    if (cur_moved && cur_oob) begin
                        collision[idx] <= 1'b1;
                    end
                    if (cur_moved && !cur_oob) begin
                        state <= ST_CHK;
                    end
                end
                ST_CHK: begin
                    if (occupied) begin
                        collision[idx] <= 1'b1;
                    end
                    old_x[idx]      <= cur_x;
                    old_y[idx]      <= cur_y;
                    old_dir[idx]    <= snap_dir[idx];
                    hist_valid[idx] <= 1'b1;
                end
                default: state <= ST_CLEAR;
            endcase
            if (advance) begin
                if (last) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= ST_RD;
                end
            end
        end
    end

endmodule

// File: tb/tb_trail_map.sv
module tb_trail_map;

    localparam int GW = 8;
    localparam int GH = 8;
    localparam int N  = 2;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int PW = 1;

    logic              clk = 1'b0;
    logic              Reset;
    logic              clear_req;
    logic              step;
    logic [N*XW-1:0]   pos_x;
    logic [N*YW-1:0]   pos_y;
    logic [N*2-1:0]    dir;
    logic              busy;
    logic              done;
    logic              step_dropped;
    logic [N-1:0]      collision;
    logic [XW-1:0]     rd_x;
    logic [YW-1:0]     rd_y;
    logic [PW+1:0]     rd_data;

    int checks   = 0;
    int failures = 0;

    // Reference model: arena contents, move history and sticky flags.
    int m_map [GW*GH];
    int m_ox [N];
    int m_oy [N];
    int m_od [N];
    bit m_valid [N];
    int m_col;
    int sx [N];
    int sy [N];
    int sd [N];

    always #5 clk = ~clk;

    trail_map #(
        .GRID_W    (GW),
        .GRID_H    (GH),
        .N_PLAYERS (N),
        .XW        (XW),
        .YW        (YW),
        .PW        (PW)
    ) dut (
        .Clk          (clk),
        .Reset        (Reset),
        .clear_req    (clear_req),
        .step         (step),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .dir          (dir),
        .busy         (busy),
        .done         (done),
        .step_dropped (step_dropped),
        .collision    (collision),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_data      (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < GW*GH; a++) m_map[a] = 0;
        for (int p = 0; p < N; p++) m_valid[p] = 1'b0;
        m_col = 0;
    endtask

    // Applies one pass to the model; returns the expected step-to-done latency.
    function automatic int model_pass();
        int lat = 2;
        bit mv [N];
        for (int p = 0; p < N; p++)
            mv[p] = !(m_valid[p] && sx[p] == m_ox[p] && sy[p] == m_oy[p]);
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++)
                if (mv[a] && mv[b] && sx[a] == sx[b] && sy[a] == sy[b])
                    m_col = m_col | (1 << a) | (1 << b);
        for (int p = 0; p < N; p++) begin
            if (!mv[p]) begin
                lat += 1;
            end else if (sx[p] >= GW || sy[p] >= GH) begin
                lat += 1;
                m_col = m_col | (1 << p);
            end else begin
                int addr = sy[p] * GW + sx[p];
                lat += 2;
                if (m_map[addr] % 4 != 0) begin
                    m_col = m_col | (1 << p);
                end else begin
                    int shape;
                    if (m_valid[p] && sd[p] != m_od[p]) shape = 3;
                    else if (sd[p] >= 2)                shape = 1;
                    else                                shape = 2;
                    m_map[addr] = p * 4 + shape;
                end
                m_ox[p] = sx[p];
                m_oy[p] = sy[p];
                m_od[p] = sd[p];
                m_valid[p] = 1'b1;
            end
        end
        return lat;
    endfunction

    task automatic apply_inputs();
        for (int p = 0; p < N; p++) begin
            pos_x[p*XW +: XW] = XW'(sx[p]);
            pos_y[p*YW +: YW] = YW'(sy[p]);
            dir[p*2 +: 2]     = 2'(sd[p]);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic do_step(input string tag, output int lat);
        int exp_lat;
        apply_inputs();
        exp_lat = model_pass();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_collision"}, collision, m_col);
        @(negedge clk);
    endtask

    task automatic read_cell(input int x, input int y, output int v);
        rd_x = XW'(x);
        rd_y = YW'(y);
        @(negedge clk);
        v = int'(rd_data);
    endtask

    task automatic check_cell(input string tag, input int x, input int y);
        int v;
        read_cell(x, y, v);
        check(tag, v, m_map[y*GW + x]);
    endtask

    // Counts busy cycles of a sweep that started at the previous rising edge.
    task automatic sweep_count(input string tag);
        int cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (cnt == 3) check({tag, "_rd_forced_zero"}, rd_data, 0);
            @(negedge clk);
        end
        check({tag, "_sweep_cycles"}, cnt, GW*GH);
    endtask

    task automatic do_clear(input string tag);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_clear();
        check({tag, "_collision_zero"}, collision, 0);
        sweep_count(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=%0t exp=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int v;
        int dones;
        Reset = 1'b1;
        clear_req = 1'b0;
        step = 1'b0;
        pos_x = '0;
        pos_y = '0;
        dir = '0;
        rd_x = XW'(3);
        rd_y = YW'(3);
        model_clear();
        for (int p = 0; p < N; p++) begin
            m_ox[p] = 0; m_oy[p] = 0; m_od[p] = 0;
        end

        // Reset for one cycle, then the 64-cycle sweep.
        @(negedge clk);
        Reset = 1'b0;
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_dropped", step_dropped, 0);
        check("rst_collision", collision, 0);
        sweep_count("rst");
        read_cell(3, 3, v);
        check("rst_cell_3_3", v, 0);

        // Straight moves for both players.
        sx = '{1, 5}; sy = '{1, 5}; sd = '{3, 0};
        do_step("t2a", lat);
        sx = '{2, 5}; sy = '{1, 4}; sd = '{3, 0};
        do_step("t2b", lat);
        check("t2_latency_6", lat, 6);
        read_cell(2, 1, v);
        check("t2_cell_2_1_horiz_p0", v, 1);
        read_cell(5, 4, v);
        check("t2_cell_5_4_vert_p1", v, 6);
        check("t2_collision_none", collision, 0);

        // Turn produces a corner; running into own trail is sticky.
        sx = '{2, 5}; sy = '{2, 4}; sd = '{1, 0};
        do_step("t3a", lat);
        read_cell(2, 2, v);
        check("t3_cell_2_2_corner", v, 3);
        sx = '{2, 5}; sy = '{1, 4}; sd = '{0, 0};
        do_step("t3b", lat);
        check("t3_col0_set", collision[0], 1);
        sx = '{2, 5}; sy = '{0, 3}; sd = '{0, 0};
        do_step("t3c", lat);
        check("t3_col0_sticky1", collision[0], 1);
        sx = '{3, 5}; sy = '{0, 3}; sd = '{3, 0};
        do_step("t3d", lat);
        check("t3_col0_sticky2", collision[0], 1);

        // Head-on into the same empty cell.
        rd_x = XW'(2); rd_y = YW'(1);
        do_clear("t4clr");
        sx = '{4, 4}; sy = '{4, 4}; sd = '{3, 3};
        do_step("t4", lat);
        check("t4_both_collide", collision, 3);
        read_cell(4, 4, v);
        check("t4_cell_owner0", v, 1);

        // Off-arena player: flagged, no write (x=8,y=2 aliases cell (0,3)).
        do_clear("t5clr");
        sx = '{1, 8}; sy = '{1, 2}; sd = '{3, 3};
        do_step("t5", lat);
        check("t5_col_p1_only", collision, 2);
        read_cell(1, 1, v);
        check("t5_cell_p0", v, 1);
        read_cell(0, 3, v);
        check("t5_alias_untouched", v, 0);

        // Second step one cycle after the first is dropped.
        sx = '{2, 8}; sy = '{1, 2}; sd = '{3, 3};
        apply_inputs();
        lat = model_pass();
        step = 1'b1;
        @(negedge clk);
        check("t6_drop_first", step_dropped, 0);
        @(negedge clk);
        step = 1'b0;
        check("t6_drop_pulse", step_dropped, 1);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("t6_single_done", dones, 1);
        check("t6_collision", collision, m_col);
        check_cell("t6_cell_2_1", 2, 1);

        // clear_req while player 0 is in CHK.
        sx = '{3, 8}; sy = '{1, 2}; sd = '{3, 3};
        apply_inputs();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rd_x = XW'(1); rd_y = YW'(1);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_clear();
        check("t7_collision_zero", collision, 0);
        check("t7_no_done", done, 0);
        sweep_count("t7");
        read_cell(3, 1, v);
        check("t7_cell_3_1", v, 0);

        // Randomized play against the model.
        for (int p = 0; p < N; p++) begin
            sx[p] = $urandom_range(0, GW-1);
            sy[p] = $urandom_range(0, GH-1);
            sd[p] = $urandom_range(0, 3);
        end
        for (int it = 0; it < 60; it++) begin
            if (it % 20 == 19) do_clear("rnd_clr");
            for (int p = 0; p < N; p++) begin
                int r = $urandom_range(0, 9);
                if (r == 2) begin
                    sx[p] = GW + $urandom_range(0, 1);
                    sy[p] = $urandom_range(0, GH-1);
                end else if (r > 2) begin
                    sx[p] = sx[p] % GW;
                    sy[p] = sy[p] % GH;
                    sd[p] = $urandom_range(0, 3);
                    case (sd[p])
                        0:       sy[p] = (sy[p] + GH - 1) % GH;
                        1:       sy[p] = (sy[p] + 1) % GH;
                        2:       sx[p] = (sx[p] + GW - 1) % GW;
                        default: sx[p] = (sx[p] + 1) % GW;
                    endcase
                end
            end
            do_step("rnd", lat);
            for (int p = 0; p < N; p++)
                if (sx[p] < GW && sy[p] < GH) check_cell("rnd_player_cell", sx[p], sy[p]);
            check_cell("rnd_any_cell", $urandom_range(0, GW-1), $urandom_range(0, GH-1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
